psg_bus_master: RTL and testbench
=================================

Name: psg_bus_master

Overview:
- Bus initiator for the PSG's BDIR/BC register interface.
- Accepts register write/read requests from CPU-side glue through a valid/ready port and queues them in a small FIFO.
- Drives each request onto the PSG pins as a latch-address phase followed by a data-write or data-read phase, separated by inactive gaps.
- Returns read data through a one-cycle response strobe. Sits between the system's I/O decode and the ym2149 instance.

Parameters:
- PHASE_CYC, 2, clocks each active bus phase (address/write/read) is held; legal range 1..15.
- FIFO_DEPTH, 4, request FIFO entries; power of two, 2..16.
- ADDR_CACHE, 1, 1 = skip address phase when request address equals last latched address.

Ports:
- CLK  in  1  system clock
- RESET  in  1  reset
- REQ_VALID  in  1  request present
- REQ_READY  out  1  FIFO can accept (not full)
- REQ_WR  in  1  1 = write, 0 = read
- REQ_ADDR  in  8  PSG register address, full 8 bits
- REQ_DATA  in  8  write data (ignored for reads)
- RSP_VALID  out  1  one-cycle read-data strobe
- RSP_DATA  out  8  last read data
- BUSY  out  1  FIFO non-empty or FSM not IDLE
- PSG_BDIR  out  1  to PSG BDIR
- PSG_BC  out  1  to PSG BC
- PSG_DO  out  8  to PSG DI
- PSG_DI  in  8  from PSG DO (combinational in PSG)

Behaviour:
- Reset is RESET, synchronous, active-high; clock is CLK. All logic uses the rising edge of CLK.
- Reset values: PSG_BDIR=0, PSG_BC=0, PSG_DO=0, RSP_VALID=0, RSP_DATA=0, BUSY=0. FIFO is emptied, address cache is invalidated, FSM enters IDLE.
- All bus outputs are registered.
- FIFO:
  - A push occurs on REQ_VALID & REQ_READY. REQ_READY = count < FIFO_DEPTH.
  - When full, REQ_READY is 0 even if a pop occurs in the same cycle.
  - Simultaneous push and pop while non-full keeps count unchanged. Order is strictly preserved.
- FSM states: IDLE, ADDR, GAP_A, WR, RD, GAP_D. A phase counter counts 0..PHASE_CYC-1.
- IDLE:
  - If the FIFO is non-empty, pop the head entry into the working register.
  - If ADDR_CACHE=1, the cache is valid, and the entry address equals the cached address, go directly to WR or RD. Otherwise go to ADDR.
  - Bus outputs 00.
- ADDR:
  - Drive BDIR=1, BC=1, PSG_DO=addr for PHASE_CYC cycles.
  - On entry, load the cache with addr and set it valid.
  - Then go to GAP_A.
- GAP_A:
  - Drive BDIR=0, BC=0 for 1 cycle; PSG_DO holds.
  - Then go to WR or RD.
- WR:
  - Drive BDIR=1, BC=0, PSG_DO=data for PHASE_CYC cycles.
  - Then go to GAP_D.
- RD:
  - Drive BDIR=0, BC=1 for PHASE_CYC cycles; PSG_DO holds.
  - Sample PSG_DI into RSP_DATA at the clock edge ending the final RD cycle.
  - RSP_VALID=1 for exactly the following cycle (the first GAP_D cycle).
  - Then go to GAP_D.
- GAP_D:
  - Drive 00 for 1 cycle, then IDLE.
  - IDLE may pop in its first cycle, so there is 1 idle cycle minimum between transactions.
- Latency:
  - A request pushed into an empty FIFO with the FSM in IDLE is popped on the next edge.
  - Its first bus phase is visible on the edge after that.
- Bus occupancy:
  - Write or read with cache miss: 2*PHASE_CYC+2 cycles.
  - With cache hit: PHASE_CYC+1 cycles.
- Addresses >= 16 are issued unmodified; the cache compares all 8 bits.
- BUSY = (count != 0) | (state != IDLE).
- RSP_DATA holds until the next read completes.
- Reset mid-operation:
  - Bus returns to 00 at the reset edge; any in-flight transaction is dropped.
  - No RSP_VALID is issued for a dropped read.
  - The cache is invalid, so the next request always issues an address phase.
- BDIR and BC never change simultaneously from 11 to 10 or from 10 to 11. A GAP cycle always separates active phases, so the PSG never sees a spurious latch or write.

Test Plan:
1. After reset, write reg 0x07=0x38 (PHASE_CYC=2) -> bus shows 11/0x07 x2, 00 x1, 10/0x38 x2, 00 x1. PSG reg7 reads 0x38. BUSY falls one cycle after the final GAP cycle.
2. Immediately write reg 0x07=0x3F -> no address phase (cache hit): 10/0x3F x2, 00. Repeat with ADDR_CACHE=0 -> full 6-cycle sequence.
3. Read reg 0x0E with PSG_DI=0xA5 -> 11/0x0E x2, 00, 01 x2. RSP_VALID high exactly 1 cycle with RSP_DATA=0xA5. RSP_DATA still 0xA5 after 10 further idle cycles.
4. Hold REQ_VALID for 8 consecutive writes (regs 0..7, data 0x10..0x17) -> REQ_READY drops once count=4. All 8 appear on the bus in order, none lost or duplicated, all accepted only on REQ_READY=1 cycles.
5. Assert RESET during the first WR cycle of a write to reg 0x08 -> bus 00 on that edge. REQ_READY=1, BUSY=0. A following write to reg 0x08 includes an address phase.
6. Write reg 0x1F=0x55 then reg 0x0F=0x55 -> both issue address phases (0x1F, then 0x0F, no cache hit). PSG registers are unchanged by the first write.

Source files
------------

// File: rtl/psg_bus_master.sv
// PSG bus initiator: queues CPU register requests and sequences each one onto
// the BDIR/BC pins as an address phase and a data phase, with idle gaps between.
module psg_bus_master #(
  parameter int PHASE_CYC  = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_CACHE = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_WR,
  input  logic [7:0] REQ_ADDR,
  input  logic [7:0] REQ_DATA,
  output logic       RSP_VALID,
  output logic [7:0] RSP_DATA,
  output logic       BUSY,
  output logic       PSG_BDIR,
  output logic       PSG_BC,
  output logic [7:0] PSG_DO,
  input  logic [7:0] PSG_DI
);

  localparam int            PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int            CW        = PW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [PW-1:0] PTR_ZERO  = PW'(0);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [3:0]    PH_LAST   = 4'(PHASE_CYC - 1);
  localparam bit            CACHE_EN  = (ADDR_CACHE != 0);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_GAP_A = 3'd2,
    ST_WR    = 3'd3,
    ST_RD    = 3'd4,
    ST_GAP_D = 3'd5
  } state_t;

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } req_t;

  req_t          fifo_mem_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] fifo_cnt_r;
  logic [CW-1:0] fifo_cnt_nxt_s;
  logic          ready_r;
  logic          push_s;
  logic          pop_s;
  logic          hit_s;
  req_t          head_s;

  state_t        state_r;
  logic [3:0]    phase_r;
  req_t          work_r;
  logic [7:0]    cache_addr_r;
  logic          cache_vld_r;

  logic          bdir_r;
  logic          bc_r;
  logic [7:0]    do_r;
  logic          rsp_valid_r;
  logic [7:0]    rsp_data_r;
  logic          busy_r;

  // Handshake, head-of-queue lookup and next FIFO occupancy
  always_comb begin
    push_s = REQ_VALID & ready_r;
    pop_s  = (state_r == ST_IDLE) && (fifo_cnt_r != CNT_ZERO);
    head_s = fifo_mem_r[rd_ptr_r];
    hit_s  = CACHE_EN && cache_vld_r && (head_s.addr == cache_addr_r);
    if (push_s && !pop_s) begin
      fifo_cnt_nxt_s = fifo_cnt_r + CNT_ONE;
    end else if (!push_s && pop_s) begin
      fifo_cnt_nxt_s = fifo_cnt_r - CNT_ONE;
    end else begin
      fifo_cnt_nxt_s = fifo_cnt_r;
    end
  end

  // Request storage; contents are don't-care until written, so no reset
  always_ff @(posedge CLK) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {REQ_WR, REQ_ADDR, REQ_DATA};
    end
  end

  // FIFO pointers, occupancy and the registered ready flag
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      fifo_cnt_r <= CNT_ZERO;
      ready_r    <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      fifo_cnt_r <= fifo_cnt_nxt_s;
      // Ready tracks the occupancy that will hold next cycle, so a full
      // FIFO stays not-ready even in a cycle where the head is popped.
      ready_r    <= (fifo_cnt_nxt_s < DEPTH_C);
    end
  end

  // Transaction sequencer; pins are decoded from the state of the previous cycle
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r      <= ST_IDLE;
      phase_r      <= 4'd0;
      work_r       <= {1'b0, 8'h00, 8'h00};
      cache_addr_r <= 8'h00;
      cache_vld_r  <= 1'b0;
      bdir_r       <= 1'b0;
      bc_r         <= 1'b0;
      do_r         <= 8'h00;
      rsp_valid_r  <= 1'b0;
      rsp_data_r   <= 8'h00;
      busy_r       <= 1'b0;
    end else begin
      busy_r      <= (fifo_cnt_r != CNT_ZERO) || (state_r != ST_IDLE);
      rsp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          bdir_r  <= 1'b0;
          bc_r    <= 1'b0;
          phase_r <= 4'd0;
          if (pop_s) begin
            work_r <= head_s;
            if (hit_s) begin
              state_r <= head_s.wr ? ST_WR : ST_RD;
            end else begin
              state_r      <= ST_ADDR;
              cache_addr_r <= head_s.addr;
              cache_vld_r  <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ADDR: begin
          bdir_r <= 1'b1;
          bc_r   <= 1'b1;
          do_r   <= work_r.addr;
          if (phase_r == PH_LAST) begin
            phase_r <= 4'd0;
            state_r <= ST_GAP_A;
          end else begin
            phase_r <= phase_r + 4'd1;
          end
        end
        ST_GAP_A: begin
          bdir_r  <= 1'b0;
          bc_r    <= 1'b0;
          state_r <= work_r.wr ? ST_WR : ST_RD;
        end
        ST_WR: begin
          bdir_r <= 1'b1;
          bc_r   <= 1'b0;
          do_r   <= work_r.data;
          if (phase_r == PH_LAST) begin
            phase_r <= 4'd0;
            state_r <= ST_GAP_D;
          end else begin
            phase_r <= phase_r + 4'd1;
          end
        end
        ST_RD: begin
          bdir_r <= 1'b0;
          bc_r   <= 1'b1;
          if (phase_r == PH_LAST) begin
            phase_r <= 4'd0;
            state_r <= ST_GAP_D;
          end else begin
            phase_r <= phase_r + 4'd1;
          end
        end
        ST_GAP_D: begin
          bdir_r  <= 1'b0;
          bc_r    <= 1'b0;
          state_r <= ST_IDLE;
          // This edge closes the last read cycle seen on the pins.
          if (!work_r.wr) begin
            rsp_data_r  <= PSG_DI;
            rsp_valid_r <= 1'b1;
          end else begin
            rsp_data_r  <= rsp_data_r;
          end
        end
        default: begin
          bdir_r  <= 1'b0;
          bc_r    <= 1'b0;
          phase_r <= 4'd0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign REQ_READY = ready_r;
  assign RSP_VALID = rsp_valid_r;
  assign RSP_DATA  = rsp_data_r;
  assign BUSY      = busy_r;
  assign PSG_BDIR  = bdir_r;
  assign PSG_BC    = bc_r;
  assign PSG_DO    = do_r;

endmodule

// File: tb/tb_psg_bus_master.sv
// Scoreboard bench for psg_bus_master: expected bus phase runs and read responses
// are queued by the stimulus and retired by a negedge monitor.
`timescale 1ns/1ps
module tb_psg_bus_master;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       req_valid_a, req_valid_b, REQ_WR;
  logic [7:0] REQ_ADDR, REQ_DATA;
  logic       ready_a, ready_b, rsp_valid_a, rsp_valid_b, busy_a, busy_b;
  logic       bdir_a, bdir_b, bc_a, bc_b;
  logic [7:0] rsp_data_a, rsp_data_b, do_a, do_b, psg_di;

  always #5 CLK = ~CLK;

  psg_bus_master u_dut (
    .CLK(CLK), .RESET(RESET), .REQ_VALID(req_valid_a), .REQ_READY(ready_a),
    .REQ_WR(REQ_WR), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .RSP_VALID(rsp_valid_a), .RSP_DATA(rsp_data_a), .BUSY(busy_a),
    .PSG_BDIR(bdir_a), .PSG_BC(bc_a), .PSG_DO(do_a), .PSG_DI(psg_di)
  );

  psg_bus_master #(.ADDR_CACHE(0)) u_dut_nc (
    .CLK(CLK), .RESET(RESET), .REQ_VALID(req_valid_b), .REQ_READY(ready_b),
    .REQ_WR(REQ_WR), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .RSP_VALID(rsp_valid_b), .RSP_DATA(rsp_data_b), .BUSY(busy_b),
    .PSG_BDIR(bdir_b), .PSG_BC(bc_b), .PSG_DO(do_b), .PSG_DI(psg_di)
  );

  // Minimal PSG register file attached to the cached instance
  logic [7:0] psg_reg [16];
  logic [7:0] psg_latch;
  assign psg_di = (psg_latch < 8'd16) ? psg_reg[psg_latch[3:0]] : 8'hFF;

  initial begin
    for (int i = 0; i < 16; i++) psg_reg[i] = 8'h00;
    psg_reg[14] = 8'hA5;
    psg_latch   = 8'h00;
    forever begin
      @(negedge CLK);
      if (bdir_a && bc_a) psg_latch = do_a;
      else if (bdir_a && !bc_a && (psg_latch < 8'd16)) psg_reg[psg_latch[3:0]] = do_a;
    end
  end

  typedef struct packed {
    logic [1:0] code;
    logic [7:0] dat;
    logic [7:0] len;
  } run_t;

  run_t       exp_q_a[$];
  run_t       exp_q_b[$];
  logic [7:0] exp_rsp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         send_waits = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic exp_run(input int inst, input logic [1:0] code, input logic [7:0] dat,
                         input int len);
    run_t r;
    r = {code, dat, 8'(len)};
    if (inst == 0) exp_q_a.push_back(r);
    else exp_q_b.push_back(r);
  endtask

  task automatic close_run(input int inst, input run_t got);
    run_t want;
    if ((inst == 0) ? (exp_q_a.size() == 0) : (exp_q_b.size() == 0)) begin
      n_checks++;
      n_fail++;
      $display("FAIL bus%0d_extra: got run code %b data 0x%0h len %0d, expected none",
               inst, got.code, got.dat, got.len);
    end else begin
      want = (inst == 0) ? exp_q_a.pop_front() : exp_q_b.pop_front();
      chk($sformatf("bus%0d_run", inst), 32'(got), 32'(want));
    end
  endtask

  // Monitor: folds the pins into phase runs and retires them against the queues
  initial begin
    logic [9:0] cur;
    logic [9:0] val [2];
    bit         act [2];
    int         len [2];
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0; val[i] = 10'd0; len[i] = 0;
    end
    forever begin
      @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
        cur = (i == 0) ? {bdir_a, bc_a, do_a} : {bdir_b, bc_b, do_b};
        if (cur[9:8] != 2'b00) begin
          if (act[i] && (val[i] == cur)) begin
            len[i]++;
          end else begin
            if (act[i]) begin
              n_checks++;
              n_fail++;
              $display("FAIL bus%0d_nogap: got 0x%0h directly after 0x%0h, expected a 00 gap",
                       i, cur, val[i]);
              close_run(i, {val[i][9:8], val[i][7:0], 8'(len[i])});
            end
            act[i] = 1'b1; val[i] = cur; len[i] = 1;
          end
        end else if (act[i]) begin
          close_run(i, {val[i][9:8], val[i][7:0], 8'(len[i])});
          act[i] = 1'b0;
        end
      end
      if (rsp_valid_a) begin
        if (exp_rsp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_extra: got RSP_VALID with 0x%0h, expected none", rsp_data_a);
        end else begin
          chk("rsp_data", 32'(rsp_data_a), 32'(exp_rsp_q.pop_front()));
        end
      end
      if (rsp_valid_b) chk("rsp_b_valid", 32'(rsp_valid_b), 32'd0);
    end
  end

  task automatic send(input int inst, input logic wr, input logic [7:0] a, input logic [7:0] d);
    int k;
    REQ_WR = wr; REQ_ADDR = a; REQ_DATA = d;
    if (inst == 0) req_valid_a = 1'b1;
    else req_valid_b = 1'b1;
    k = 0;
    while (((inst == 0) ? !ready_a : !ready_b) && (k < 200)) begin
      @(negedge CLK);
      k++;
    end
    if (k > 0) send_waits++;
    if (k == 200) chk("send_timeout", 32'd1, 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    repeat (2) @(negedge CLK);
    k = 0;
    while ((busy_a || busy_b) && (k < 200)) begin
      @(negedge CLK);
      k++;
    end
    chk("idle", 32'(busy_a | busy_b), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] t1_vec [8];
    int k;
    int first_wait;
    RESET = 1'b1; req_valid_a = 1'b0; req_valid_b = 1'b0;
    REQ_WR = 1'b0; REQ_ADDR = 8'h00; REQ_DATA = 8'h00;
    repeat (3) @(negedge CLK);
    chk("rst_bus", 32'({bdir_a, bc_a, do_a}), 32'd0);
    chk("rst_rsp", 32'({rsp_valid_a, rsp_data_a}), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_ready", 32'(ready_a), 32'd1);
    RESET = 1'b0;
    @(negedge CLK);

    // 1: write 0x07=0x38 with a cycle-exact view of {BUSY,BDIR,BC}
    exp_run(0, 2'b11, 8'h07, 2); exp_run(0, 2'b10, 8'h38, 2);
    t1_vec = '{3'b100, 3'b111, 3'b111, 3'b100, 3'b110, 3'b110, 3'b100, 3'b000};
    send(0, 1'b1, 8'h07, 8'h38);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      chk($sformatf("t1_cycle%0d", i + 1), 32'({busy_a, bdir_a, bc_a}), 32'(t1_vec[i]));
    end
    wait_idle();
    chk("t1_psg_reg7", 32'(psg_reg[7]), 32'h38);

    // 2: cache hit, then the same address on the uncached instance, then read back
    exp_run(0, 2'b10, 8'h3F, 2);
    send(0, 1'b1, 8'h07, 8'h3F);
    wait_idle();
    chk("t2_psg_reg7", 32'(psg_reg[7]), 32'h3F);
    exp_run(1, 2'b11, 8'h07, 2); exp_run(1, 2'b10, 8'h38, 2);
    exp_run(1, 2'b11, 8'h07, 2); exp_run(1, 2'b10, 8'h3F, 2);
    send(1, 1'b1, 8'h07, 8'h38);
    send(1, 1'b1, 8'h07, 8'h3F);
    wait_idle();
    exp_run(0, 2'b01, 8'h3F, 2); exp_rsp_q.push_back(8'h3F);
    send(0, 1'b0, 8'h07, 8'h00);
    wait_idle();

    // 3: read 0x0E (port value 0xA5), response held afterwards
    exp_run(0, 2'b11, 8'h0E, 2); exp_run(0, 2'b01, 8'h0E, 2); exp_rsp_q.push_back(8'hA5);
    send(0, 1'b0, 8'h0E, 8'h00);
    wait_idle();
    repeat (10) @(negedge CLK);
    chk("t3_rsp_hold", 32'({rsp_valid_a, rsp_data_a}), 32'h0A5);

    // 4: eight back-to-back writes against a four-entry FIFO
    for (int i = 0; i < 8; i++) begin
      exp_run(0, 2'b11, 8'(i), 2); exp_run(0, 2'b10, 8'(8'h10 + i), 2);
    end
    first_wait = -1;
    for (int i = 0; i < 8; i++) begin
      k = send_waits;
      send(0, 1'b1, 8'(i), 8'(8'h10 + i));
      if ((send_waits != k) && (first_wait < 0)) first_wait = i;
    end
    chk("t4_first_stall", 32'(first_wait), 32'd5);
    wait_idle();
    chk("t4_psg_reg3", 32'(psg_reg[3]), 32'h13);

    // 5: reset during the first write cycle of reg 0x08
    exp_run(0, 2'b11, 8'h08, 2); exp_run(0, 2'b10, 8'h77, 1);
    send(0, 1'b1, 8'h08, 8'h77);
    k = 0;
    while (!(bdir_a && !bc_a) && (k < 50)) begin
      @(negedge CLK);
      k++;
    end
    chk("t5_reach_wr", 32'(k < 50), 32'd1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("t5_bus_cleared", 32'({bdir_a, bc_a}), 32'd0);
    chk("t5_ready", 32'(ready_a), 32'd1);
    chk("t5_busy", 32'(busy_a), 32'd0);
    exp_run(0, 2'b11, 8'h08, 2); exp_run(0, 2'b10, 8'h99, 2);
    send(0, 1'b1, 8'h08, 8'h99);
    wait_idle();

    // 6: 0x1F is not a PSG register; 0x0F must not hit the cache
    exp_run(0, 2'b11, 8'h1F, 2); exp_run(0, 2'b10, 8'h55, 2);
    send(0, 1'b1, 8'h1F, 8'h55);
    wait_idle();
    chk("t6_reg15_untouched", 32'(psg_reg[15]), 32'h00);
    exp_run(0, 2'b11, 8'h0F, 2); exp_run(0, 2'b10, 8'h55, 2);
    send(0, 1'b1, 8'h0F, 8'h55);
    wait_idle();
    chk("t6_reg15", 32'(psg_reg[15]), 32'h55);

    repeat (4) @(negedge CLK);
    chk("exp_a_drained", 32'(exp_q_a.size()), 32'd0);
    chk("exp_b_drained", 32'(exp_q_b.size()), 32'd0);
    chk("rsp_drained", 32'(exp_rsp_q.size()), 32'd0);
    chk("b_rsp_data", 32'(rsp_data_b), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
